// File: rtl/barrel_shift_r.sv
// Clocked logical right barrel shifter with zero fill.
// A cascade of power-of-two mux stages feeds a single output register.
module barrel_shift_r #(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   shift_str,
    input  logic [SHIFT_W-1:0] shift_amnt,
    output logic [WIDTH-1:0]   shifted_str
);

    logic [WIDTH-1:0] stage [SHIFT_W+1];

    assign stage[0] = shift_str;

    // Stage k shifts by 2^k when shift_amnt[k] is set; the net result is the sum of the enabled distances.
    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        localparam int DIST = 1 << k;
        assign stage[k+1] = shift_amnt[k] ? {{DIST{1'b0}}, stage[k][WIDTH-1:DIST]}
                                          : stage[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifted_str <= '0;
        end else begin
            shifted_str <= stage[SHIFT_W];
        end
    end

endmodule

// File: tb/tb_barrel_shift_r.sv
// Self-checking bench for barrel_shift_r: directed table, latency and async-reset
// sequences, and a randomized sweep against an arithmetic reference model.
module tb_barrel_shift_r;

    localparam int WIDTH   = 32;
    localparam int SHIFT_W = 5;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   shift_str;
    logic [SHIFT_W-1:0] shift_amnt;
    logic [WIDTH-1:0]   shifted_str;

    int total;
    int bad;

    typedef struct {
        logic [WIDTH-1:0]   str;
        logic [SHIFT_W-1:0] amnt;
        logic [WIDTH-1:0]   expected;
    } vec_t;

    vec_t vecs [8];

    barrel_shift_r #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .shift_str  (shift_str),
        .shift_amnt (shift_amnt),
        .shifted_str(shifted_str)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: logical right shift is integer division by 2^amount.
    function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] str,
                                                  input logic [SHIFT_W-1:0] amnt);
        longint unsigned num;
        longint unsigned den;
        num = longint'(str);
        den = 64'd1;
        for (int i = 0; i < int'(amnt); i++) den = den * 2;
        return WIDTH'(num / den);
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] str, input logic [SHIFT_W-1:0] amnt);
        @(negedge clk);
        shift_str  = str;
        shift_amnt = amnt;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expected);
        total++;
        if (shifted_str !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, shifted_str, expected);
        end
    endtask

    task automatic stepAndCheck(input string name, input logic [WIDTH-1:0] str,
                                input logic [SHIFT_W-1:0] amnt);
        applyStimulus(str, amnt);
        @(posedge clk);
        #1;
        checkOutput(name, refShift(str, amnt));
    endtask

    initial begin
        logic [WIDTH-1:0]   r_str;
        logic [SHIFT_W-1:0] r_amnt;
        logic [WIDTH-1:0]   prev_exp;

        total = 0;
        bad   = 0;

        vecs[0] = '{32'hD6975971, 5'd4,  32'h0D697597};
        vecs[1] = '{32'hD6975971, 5'd2,  32'h35A5D65C};
        vecs[2] = '{32'hD6975971, 5'd3,  32'h1AD2EB2E};
        vecs[3] = '{32'hD6975971, 5'd5,  32'h06B4BACB};
        vecs[4] = '{32'hD6975971, 5'd10, 32'h0035A5D6};
        vecs[5] = '{32'hD6975971, 5'd0,  32'hD6975971};
        vecs[6] = '{32'hD6975971, 5'd31, 32'h00000001};
        vecs[7] = '{32'h80000000, 5'd31, 32'h00000001};

        // Reset: asynchronous clear, held while rst is high across edges.
        rst        = 1'b0;
        shift_str  = 32'hFFFFFFFF;
        shift_amnt = 5'd0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", '0);

        // Release: the next edge loads the current inputs.
        @(negedge clk);
        shift_str  = 32'hD6975971;
        shift_amnt = 5'd4;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 32'h0D697597);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].str, vecs[i].amnt);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expected);
        end

        applyStimulus(32'h00000000, 5'd17);
        @(posedge clk);
        #1;
        checkOutput("zero_input", 32'h00000000);

        // Mid-cycle input change must not reach the output before the next edge.
        stepAndCheck("latency_a", 32'hCAFEBABE, 5'd8);
        #2;
        shift_str  = 32'h12345678;
        shift_amnt = 5'd1;
        #1;
        checkOutput("latency_hold", 32'h00CAFEBA);
        @(posedge clk);
        #1;
        checkOutput("latency_update", 32'h091A2B3C);

        // Back-to-back operands, one result per cycle in order.
        for (int i = 0; i < 6; i++) begin
            stepAndCheck($sformatf("b2b%0d", i), 32'hF0F0A5A5 ^ (32'h11111111 * i), SHIFT_W'(i * 3));
        end

        // Async reset mid-stream, then clean resumption.
        stepAndCheck("pre_reset", 32'hDEADBEEF, 5'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_async", '0);
        @(posedge clk);
        #1;
        checkOutput("midreset_held", '0);
        @(negedge clk);
        shift_str  = 32'h87654321;
        shift_amnt = 5'd12;
        rst        = 1'b0;
        #1;
        checkOutput("midreset_no_stale", '0);
        @(posedge clk);
        #1;
        checkOutput("midreset_resume", 32'h00087654);

        // Randomized sweep over every amount.
        prev_exp = '0;
        for (int a = 0; a < WIDTH; a++) begin
            for (int j = 0; j < 3; j++) begin
                r_str  = $urandom;
                r_amnt = SHIFT_W'(a);
                stepAndCheck($sformatf("rand_a%0d_%0d", a, j), r_str, r_amnt);
                prev_exp = refShift(r_str, r_amnt);
            end
        end
        r_str = $urandom;
        #2;
        shift_str = r_str;
        #1;
        checkOutput("rand_hold", prev_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
